// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
//   Shared definitions for the instruction-memory loader:
//     - state_t    : loader FSM state encoding (also exported on state_dbg)
//     - DEPTH_DEF  : default number of instruction words
//     - HALF_W     : width of one download halfword
//     - INST_W     : width of one instruction word
// ---------------------------------------------------------------------------
package loader_pkg;

   localparam int DEPTH_DEF = 16;
   localparam int HALF_W    = 16;
   localparam int INST_W    = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CHK  = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

endpackage

// File: rtl/inst_mem_ram.sv
// ---------------------------------------------------------------------------
// inst_mem_ram
//   DEPTH x INST_W instruction store. One write port, one synchronous read
//   port, asynchronous clear of every entry and of the read register.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low clear
//     we, waddr, wdata  write port (written on rising edge when we=1)
//     rd_en             when low the read register loads 0 instead of mem
//     raddr, rdata      synchronous read, one-cycle latency, read-before-write
// ---------------------------------------------------------------------------
module inst_mem_ram
   import loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [INST_W-1:0] wdata,
   input  logic              rd_en,
   input  logic [AW-1:0]     raddr,
   output logic [INST_W-1:0] rdata
);

   logic [INST_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Non-blocking read sees the pre-write contents, so a same-address
   // read/write in one cycle returns the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rdata <= '0;
      else if (rd_en) rdata <= mem[raddr];
      else            rdata <= '0;
   end

endmodule

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
//   Downloads a program frame over a 16-bit halfword stream into an
//   instruction RAM and serves CPU fetches from it.
//   Frame: header N, then N (upper, lower) halfword pairs, then a checksum
//   halfword equal to the XOR of header and all data halfwords.
//   Handshake: a halfword is consumed on a rising edge where din_valid and
//   din_ready are both high; din_valid low simply stalls the FSM.
//   Ports:
//     clk, sys_rst        clock, asynchronous active-low reset
//     load_start          one-cycle download request (ignored while busy)
//     din, din_valid      halfword stream in
//     din_ready           loader accepts din this cycle
//     load_busy           download in progress (CPU holds fetch)
//     load_done, load_err registered result of the last download
//     inst_count          valid instruction count after a good load
//     fetch_addr          CPU fetch address
//     fetch_inst          fetched word, one cycle after fetch_addr
//     state_dbg           current FSM state (loader_pkg::state_t encoding)
// ---------------------------------------------------------------------------
module inst_mem_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              sys_rst,
   input  logic              load_start,
   input  logic [HALF_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic [AW:0]       inst_count,
   input  logic [AW-1:0]     fetch_addr,
   output logic [INST_W-1:0] fetch_inst,
   output logic [2:0]        state_dbg
);

   localparam logic [AW:0] DEPTH_N = DEPTH[AW:0];

   state_t            state;
   logic [HALF_W-1:0] csum;
   logic [HALF_W-1:0] upper;
   logic [AW-1:0]     wr_addr;
   logic [AW:0]       n_reg;
   logic [AW:0]       hdr_n;
   logic              xfer;
   logic              mem_we;
   logic              last_word;

   assign hdr_n     = din[AW:0];
   assign load_busy = (state == ST_HDR) || (state == ST_HI) ||
                      (state == ST_LO)  || (state == ST_CHK);
   assign din_ready = load_busy;
   assign xfer      = din_valid && din_ready;
   assign mem_we    = (state == ST_LO) && xfer;
   assign last_word = ({1'b0, wr_addr} == (n_reg - 1'b1));
   assign state_dbg = state;

   always_ff @(posedge clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state      <= ST_IDLE;
         csum       <= '0;
         upper      <= '0;
         wr_addr    <= '0;
         n_reg      <= '0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         inst_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (load_start) begin
                  state     <= ST_HDR;
                  load_done <= 1'b0;
                  load_err  <= 1'b0;
                  csum      <= '0;
               end
            end
            ST_HDR: begin
               if (xfer) begin
                  if (hdr_n == '0 || hdr_n > DEPTH_N) begin
                     state      <= ST_ERR;
                     load_err   <= 1'b1;
                     inst_count <= '0;
                  end else begin
                     n_reg   <= hdr_n;
                     wr_addr <= '0;
                     csum    <= din;
                     state   <= ST_HI;
                  end
               end
            end
            ST_HI: begin
               if (xfer) begin
                  upper <= din;
                  csum  <= csum ^ din;
                  state <= ST_LO;
               end
            end
            ST_LO: begin
               if (xfer) begin
                  csum <= csum ^ din;
                  // Hold wr_addr on the last word so a full-depth load ends
                  // at DEPTH-1 rather than wrapping to 0.
                  if (last_word) begin
                     state <= ST_CHK;
                  end else begin
                     wr_addr <= wr_addr + 1'b1;
                     state   <= ST_HI;
                  end
               end
            end
            ST_CHK: begin
               if (xfer) begin
                  if (din == csum) begin
                     state      <= ST_DONE;
                     load_done  <= 1'b1;
                     inst_count <= n_reg;
                  end else begin
                     state      <= ST_ERR;
                     load_err   <= 1'b1;
                     inst_count <= '0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   inst_mem_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rst_n (sys_rst),
      .we    (mem_we),
      .waddr (wr_addr),
      .wdata ({upper, din}),
      .rd_en (!load_busy),
      .raddr (fetch_addr),
      .rdata (fetch_inst)
   );

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_mem_loader
//   Directed bench for inst_mem_loader: good load, bad checksum, bad
//   headers, stalled stream, reset mid-load, full-depth load with an
//   ignored load_start.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;
   import loader_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic              clk;
   logic              sys_rst;
   logic              load_start;
   logic [15:0]       din;
   logic              din_valid;
   logic              din_ready;
   logic              load_busy;
   logic              load_done;
   logic              load_err;
   logic [AW:0]       inst_count;
   logic [AW-1:0]     fetch_addr;
   logic [31:0]       fetch_inst;
   logic [2:0]        state_dbg;

   int n_chk;
   int n_fail;
   logic [15:0] frame[$];
   logic [31:0] exp_q[$];

   inst_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .load_start (load_start),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .load_busy  (load_busy),
      .load_done  (load_done),
      .load_err   (load_err),
      .inst_count (inst_count),
      .fetch_addr (fetch_addr),
      .fetch_inst (fetch_inst),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_hw(input logic [15:0] h, input int gap);
      int w;
      repeat (gap) begin
         din_valid = 1'b0;
         din       = 16'hDEAD;
         tick();
      end
      din       = h;
      din_valid = 1'b1;
      w = 0;
      while (!din_ready && w < 20) begin
         tick();
         w++;
      end
      if (!din_ready) chk("ready_timeout", {31'b0, din_ready}, 32'd1);
      tick();
      din_valid = 1'b0;
   endtask

   task automatic send_frame(input int gap);
      foreach (frame[k]) send_hw(frame[k], gap);
   endtask

   task automatic fetch_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
      fetch_addr = a;
      tick();
      chk(tag, fetch_inst, exp);
   endtask

   task automatic load_good_frame();
      frame = '{16'h0002, 16'h0840, 16'h0005, 16'h0880, 16'h0003, 16'h00C4};
   endtask

   task automatic check_good(input string tag);
      chk({tag, "_state"}, {29'b0, state_dbg}, {29'b0, ST_DONE});
      chk({tag, "_done"},  {31'b0, load_done}, 32'd1);
      chk({tag, "_err"},   {31'b0, load_err},  32'd0);
      chk({tag, "_count"}, {27'b0, inst_count}, 32'd2);
      fetch_chk({tag, "_fetch0"}, 4'd0, 32'h08400005);
      fetch_chk({tag, "_fetch1"}, 4'd1, 32'h08800003);
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      sys_rst    = 1'b0;
      load_start = 1'b0;
      din        = '0;
      din_valid  = 1'b0;
      fetch_addr = '0;
      repeat (3) tick();

      // reset state
      chk("rst_state", {29'b0, state_dbg}, {29'b0, ST_IDLE});
      chk("rst_ready", {31'b0, din_ready}, 32'd0);
      chk("rst_busy",  {31'b0, load_busy}, 32'd0);
      chk("rst_done",  {31'b0, load_done}, 32'd0);
      chk("rst_err",   {31'b0, load_err},  32'd0);
      chk("rst_count", {27'b0, inst_count}, 32'd0);
      chk("rst_fetch", fetch_inst, 32'd0);
      sys_rst = 1'b1;
      repeat (2) tick();

      // good load, with fetch blanking while busy
      load_good_frame();
      pulse_start();
      chk("start_state", {29'b0, state_dbg}, {29'b0, ST_HDR});
      chk("start_busy",  {31'b0, load_busy}, 32'd1);
      chk("start_ready", {31'b0, din_ready}, 32'd1);
      tick();
      chk("busy_fetch_zero", fetch_inst, 32'd0);
      send_frame(0);
      check_good("good");

      // bad checksum: data still written, count forced to 0
      frame[5] = 16'h00C5;
      pulse_start();
      chk("badck_done_clr", {31'b0, load_done}, 32'd0);
      send_frame(0);
      chk("badck_state", {29'b0, state_dbg}, {29'b0, ST_ERR});
      chk("badck_err",   {31'b0, load_err},  32'd1);
      chk("badck_done",  {31'b0, load_done}, 32'd0);
      chk("badck_count", {27'b0, inst_count}, 32'd0);
      fetch_chk("badck_kept0", 4'd0, 32'h08400005);

      // bad headers: ERR right after header, memory untouched
      pulse_start();
      send_hw(16'h0000, 0);
      chk("hdr0_state", {29'b0, state_dbg}, {29'b0, ST_ERR});
      chk("hdr0_err",   {31'b0, load_err},  32'd1);
      chk("hdr0_count", {27'b0, inst_count}, 32'd0);
      pulse_start();
      send_hw(16'h0011, 0);
      chk("hdr17_state", {29'b0, state_dbg}, {29'b0, ST_ERR});
      chk("hdr17_err",   {31'b0, load_err},  32'd1);
      fetch_chk("hdr_mem0", 4'd0, 32'h08400005);
      fetch_chk("hdr_mem1", 4'd1, 32'h08800003);

      // clear memory, then stalled good load
      sys_rst = 1'b0;
      tick();
      sys_rst = 1'b1;
      tick();
      fetch_chk("clr_mem0", 4'd0, 32'd0);
      load_good_frame();
      pulse_start();
      send_frame(3);
      check_good("stall");

      // reset mid-load after the 3rd halfword
      pulse_start();
      send_hw(frame[0], 0);
      send_hw(frame[1], 0);
      send_hw(frame[2], 0);
      sys_rst = 1'b0;
      #1;
      chk("mid_rst_state", {29'b0, state_dbg}, {29'b0, ST_IDLE});
      chk("mid_rst_busy",  {31'b0, load_busy}, 32'd0);
      chk("mid_rst_ready", {31'b0, din_ready}, 32'd0);
      chk("mid_rst_done",  {31'b0, load_done}, 32'd0);
      chk("mid_rst_err",   {31'b0, load_err},  32'd0);
      chk("mid_rst_count", {27'b0, inst_count}, 32'd0);
      chk("mid_rst_fetch", fetch_inst, 32'd0);
      tick();
      sys_rst = 1'b1;
      fetch_chk("mid_rst_mem0", 4'd0, 32'd0);
      tick();
      chk("mid_rst_idle", {29'b0, state_dbg}, {29'b0, ST_IDLE});
      pulse_start();
      send_frame(0);
      check_good("after_rst");

      // full depth, mem[i] = {i,i}, checksum = header (pairs cancel)
      frame = '{16'h0010};
      exp_q = {};
      for (int i = 0; i < DEPTH; i++) begin
         frame.push_back(16'(i));
         frame.push_back(16'(i));
         exp_q.push_back({16'(i), 16'(i)});
      end
      frame.push_back(16'h0010);
      pulse_start();
      foreach (frame[k]) begin
         if (k == 7) load_start = 1'b1;
         send_hw(frame[k], 0);
         load_start = 1'b0;
         if (k == 7) chk("ovl_busy", {31'b0, load_busy}, 32'd1);
      end
      chk("full_state", {29'b0, state_dbg}, {29'b0, ST_DONE});
      chk("full_done",  {31'b0, load_done}, 32'd1);
      chk("full_count", {27'b0, inst_count}, 32'd16);
      for (int i = 0; i < DEPTH; i++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         fetch_chk($sformatf("full_mem%0d", i), 4'(i), e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 Parameter DEPTH, default 16: number of 32-bit instruction words held.
REQ-002 Parameter AW, default 4: address width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-low.
REQ-005 load_start  input  1  single-cycle request to begin a program download.
REQ-006 din  input  16  download halfword stream.
REQ-007 din_valid  input  1  din carries a valid halfword.
REQ-008 din_ready  output  1  loader accepts din this cycle.
REQ-009 load_busy  output  1  download in progress; the CPU SHALL hold fetch while high.
REQ-010 load_done  output  1  last download completed with a good checksum.
REQ-011 load_err  output  1  last download failed.
REQ-012 inst_count  output  AW+1  number of valid instructions, range 0..DEPTH.
REQ-013 fetch_addr  input  AW  CPU instruction fetch address (the CPU's PC).
REQ-014 fetch_inst  output  32  instruction word returned for fetch_addr.

Function
REQ-015 Frame format, in this order:
- header halfword: N = din[AW:0]
- N pairs of halfwords: upper half first, then lower half
- one checksum halfword equal to the XOR of the header and all 2N data halfwords.
REQ-016 A halfword transfer SHALL occur only on a cycle where din_valid and din_ready are both high.
REQ-017 FSM states SHALL be IDLE, HDR, HI, LO, CHK, DONE and ERR.
REQ-018 din_ready SHALL be high in HDR, HI, LO and CHK, and low in all other states.
REQ-019 IDLE, DONE, ERR: load_start SHALL move the FSM to HDR and clear load_done, load_err and the checksum accumulator.
REQ-020 HDR, on transfer:
- if N==0 or N>DEPTH, go to ERR;
- otherwise latch N, set wr_addr=0, set csum=din, go to HI.
REQ-021 HI, on transfer: latch din as the upper half, XOR din into csum, go to LO.
REQ-022 LO, on transfer:
- write {upper, din} to mem[wr_addr] and XOR din into csum;
- if wr_addr==N-1 go to CHK, otherwise increment wr_addr and go to HI.
REQ-023 CHK, on transfer: if din==csum go to DONE with inst_count=N; otherwise go to ERR with inst_count=0.
REQ-024 load_busy SHALL be high exactly in states HDR, HI, LO and CHK.
REQ-025 load_done SHALL be high only in DONE, and load_err only in ERR; both SHALL be registered outputs.
REQ-026 load_start SHALL be ignored while load_busy is high.
REQ-027 Idle gaps on din_valid between any two halfwords SHALL stall the FSM without changing any state.
REQ-028 Fetch latency SHALL be one cycle: fetch_inst = mem[fetch_addr] as sampled at the previous edge.
REQ-029 fetch_inst SHALL read 0 whenever load_busy was high at the sampling edge.
REQ-030 A fetch and a write to the same address in the same cycle SHALL return the old contents.
REQ-031 A failed load SHALL leave the entries already written in memory, but inst_count SHALL report 0.
REQ-032 wr_addr SHALL never exceed DEPTH-1; a full-depth load SHALL end at address DEPTH-1 with no wrap.

Reset
REQ-033 Assertion of sys_rst, including mid-download, SHALL immediately force:
- state IDLE;
- din_ready, load_busy, load_done, load_err, inst_count and fetch_inst to 0;
- csum, wr_addr and the upper-half register to 0;
- all memory entries to 0.
REQ-034 After reset is released, no download SHALL begin until a new load_start.

Structure
REQ-035 Package loader_pkg SHALL hold the FSM state enum, DEPTH_DEF=16 and the halfword and instruction width constants.
REQ-036 Storage SHALL be one sub-module, inst_mem_ram: DEPTH x 32, one write port, synchronous read, asynchronous clear.
REQ-037 The FSM, checksum and counters SHALL reside in inst_mem_loader.

Verification
REQ-038 Good load: stream 0x0002, 0x0840, 0x0005, 0x0880, 0x0003, 0x00C4 -> load_done=1, inst_count=2; fetch_addr 0 gives 0x08400005 and fetch_addr 1 gives 0x08800003, each one cycle later.
REQ-039 Bad checksum: same data with checksum 0x00C5 -> load_err=1, inst_count=0, load_done=0.
REQ-040 Bad header: header 0x0000, and separately header 0x0011 -> ERR on the cycle after the header transfer; no memory writes.
REQ-041 Stalls: good-load stream with din_valid low for 3 cycles between every halfword -> identical result to REQ-038.
REQ-042 Reset mid-load: sys_rst low after the 3rd halfword -> all outputs 0, state IDLE; fetch of address 0 returns 0; a following load_start and good load succeeds.
REQ-043 Full depth and overlap:
- 16 instructions with mem[i]={i,i}, correct checksum -> inst_count=16, address 15 correct;
- a load_start pulsed mid-load is ignored.
